// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle LEGv8 sequencer.
// Walks each instruction through fetch, decode, execute, memory and write-back,
// drives the datapath enables, owns the shared memory req/ack port and counts
// retired instructions.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [10:0]      inst31_21_i,
  input  logic             zero_i,
  input  logic             mem_ack_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             i_or_d_o,
  output logic             IRWrite_o,
  output logic             PCWrite_o,
  output logic [1:0]       PCSrc_o,
  output logic [1:0]       ALUOp_o,
  output logic             ALUSrc_o,
  output logic             Reg2Loc_o,
  output logic             RegWrite_o,
  output logic             MemtoReg_o,
  output logic             trap_o,
  output logic             retired_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    EX_R    = 4'd3,
    EX_I    = 4'd4,
    EX_ADDR = 4'd5,
    MEM_RD  = 4'd6,
    MEM_WR  = 4'd7,
    WB_R    = 4'd8,
    WB_LD   = 4'd9,
    BR_CBZ  = 4'd10,
    BR_B    = 4'd11,
    TRAP    = 4'd12
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic             isStur;

  // LDUR and STUR differ only in bit 1; the IR holds the opcode until the next fetch.
  assign isStur = (inst31_21_i == 11'b11111000000);

  // State and retire counter registers; reset forces IDLE so every output drops at once.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Next-state logic: opcode decode in DECODE, handshake waits in the memory states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (mem_ack_i) state_d = DECODE;
      DECODE: begin
        casez (inst31_21_i)
          11'b10001011000,
          11'b11001011000,
          11'b10001010000,
          11'b10101010000: state_d = EX_R;
          11'b1001000100?: state_d = EX_I;
          11'b11111000010,
          11'b11111000000: state_d = EX_ADDR;
          11'b10110100???: state_d = BR_CBZ;
          11'b000101?????: state_d = BR_B;
          default:         state_d = TRAP;
        endcase
      end
      EX_R:    state_d = WB_R;
      EX_I:    state_d = WB_R;
      EX_ADDR: state_d = isStur ? MEM_WR : MEM_RD;
      MEM_RD:  if (mem_ack_i) state_d = WB_LD;
      MEM_WR:  if (mem_ack_i) state_d = FETCH;
      WB_R:    state_d = FETCH;
      WB_LD:   state_d = FETCH;
      BR_CBZ:  state_d = FETCH;
      BR_B:    state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  // Datapath controls decoded from the state; FETCH/MEM_WR completions and CBZ PCWrite follow their inputs.
  always_comb begin
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    i_or_d_o   = 1'b0;
    IRWrite_o  = 1'b0;
    PCWrite_o  = 1'b0;
    PCSrc_o    = 2'b00;
    ALUOp_o    = 2'b00;
    ALUSrc_o   = 1'b0;
    Reg2Loc_o  = 1'b0;
    RegWrite_o = 1'b0;
    MemtoReg_o = 1'b0;
    trap_o     = 1'b0;
    retired_o  = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req_o = 1'b1;
        IRWrite_o = mem_ack_i;
        PCWrite_o = mem_ack_i;
      end
      EX_R: begin
        ALUOp_o = 2'b10;
      end
      EX_I: begin
        ALUOp_o  = 2'b10;
        ALUSrc_o = 1'b1;
      end
      EX_ADDR: begin
        ALUSrc_o  = 1'b1;
        Reg2Loc_o = isStur;
      end
      MEM_RD: begin
        mem_req_o = 1'b1;
        i_or_d_o  = 1'b1;
      end
      MEM_WR: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        i_or_d_o  = 1'b1;
        retired_o = mem_ack_i;
      end
      WB_R: begin
        RegWrite_o = 1'b1;
        retired_o  = 1'b1;
      end
      WB_LD: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = 1'b1;
        retired_o  = 1'b1;
      end
      BR_CBZ: begin
        ALUOp_o   = 2'b01;
        Reg2Loc_o = 1'b1;
        PCSrc_o   = 2'b01;
        PCWrite_o = zero_i;
        retired_o = 1'b1;
      end
      BR_B: begin
        PCSrc_o   = 2'b10;
        PCWrite_o = 1'b1;
        retired_o = 1'b1;
      end
      TRAP: begin
        trap_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Retire counter advances on every retired pulse and wraps naturally.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (retired_o) retire_cnt_d = retire_cnt_q + CNT_W'(1);
  end

  assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control (counter width 4 so the wrap is reachable).
module tb_multicycle_control;

  localparam int CNT_W = 4;

  // Opcodes
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_ADDI = 11'b10010001000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_BAD  = 11'b11111111111;

  // Output vector: {req,we,iod}_{IRWrite,PCWrite}_{PCSrc}_{ALUOp}_{ALUSrc,Reg2Loc}_{RegWrite,MemtoReg}_{trap,retired}
  localparam logic [14:0] E_ZERO     = 15'b000_00_00_00_00_00_00;
  localparam logic [14:0] E_FETCH_W  = 15'b100_00_00_00_00_00_00;
  localparam logic [14:0] E_FETCH_A  = 15'b100_11_00_00_00_00_00;
  localparam logic [14:0] E_DECODE   = 15'b000_00_00_00_00_00_00;
  localparam logic [14:0] E_EX_R     = 15'b000_00_00_10_00_00_00;
  localparam logic [14:0] E_EX_I     = 15'b000_00_00_10_10_00_00;
  localparam logic [14:0] E_EXA_LD   = 15'b000_00_00_00_10_00_00;
  localparam logic [14:0] E_EXA_ST   = 15'b000_00_00_00_11_00_00;
  localparam logic [14:0] E_MEM_RD   = 15'b101_00_00_00_00_00_00;
  localparam logic [14:0] E_MEM_WR_W = 15'b111_00_00_00_00_00_00;
  localparam logic [14:0] E_MEM_WR_A = 15'b111_00_00_00_00_00_01;
  localparam logic [14:0] E_WB_R     = 15'b000_00_00_00_00_10_01;
  localparam logic [14:0] E_WB_LD    = 15'b000_00_00_00_00_11_01;
  localparam logic [14:0] E_CBZ_T    = 15'b000_01_01_01_01_00_01;
  localparam logic [14:0] E_CBZ_N    = 15'b000_00_01_01_01_00_01;
  localparam logic [14:0] E_BR_B     = 15'b000_01_10_00_00_00_01;
  localparam logic [14:0] E_TRAP     = 15'b000_00_00_00_00_00_10;

  logic             clk;
  logic             reset_n;
  logic [10:0]      inst31_21;
  logic             zero;
  logic             mem_ack;
  logic             mem_req, mem_we, i_or_d, IRWrite, PCWrite;
  logic [1:0]       PCSrc, ALUOp;
  logic             ALUSrc, Reg2Loc, RegWrite, MemtoReg, trap, retired;
  logic [CNT_W-1:0] retire_cnt;
  logic [14:0]      outVec;

  int errors = 0;
  int checks = 0;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .inst31_21_i  (inst31_21),
    .zero_i       (zero),
    .mem_ack_i    (mem_ack),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .i_or_d_o     (i_or_d),
    .IRWrite_o    (IRWrite),
    .PCWrite_o    (PCWrite),
    .PCSrc_o      (PCSrc),
    .ALUOp_o      (ALUOp),
    .ALUSrc_o     (ALUSrc),
    .Reg2Loc_o    (Reg2Loc),
    .RegWrite_o   (RegWrite),
    .MemtoReg_o   (MemtoReg),
    .trap_o       (trap),
    .retired_o    (retired),
    .retire_cnt_o (retire_cnt)
  );

  assign outVec = {mem_req, mem_we, i_or_d, IRWrite, PCWrite, PCSrc, ALUOp,
                   ALUSrc, Reg2Loc, RegWrite, MemtoReg, trap, retired};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs just after the falling edge and settle 1 time unit before checking.
  task automatic applyStimulus(input logic ack, input logic z, input logic [10:0] inst);
    @(negedge clk);
    mem_ack   = ack;
    zero      = z;
    inst31_21 = inst;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [14:0] expected);
    checks++;
    assert (outVec === expected) else begin
      errors++;
      $error("[TB] FAIL %s outputs got=%b exp=%b", tag, outVec, expected);
    end
  endtask

  task automatic checkCount(input string tag, input logic [CNT_W-1:0] expected);
    checks++;
    assert (retire_cnt === expected) else begin
      errors++;
      $error("[TB] FAIL %s retire_cnt got=%0d exp=%0d", tag, retire_cnt, expected);
    end
  endtask

  // Assert reset mid-cycle, hold it over a rising edge, release at a falling edge.
  task automatic pulseReset();
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("reset_async", E_ZERO);
    checkCount("reset_cnt", 4'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("post_reset_idle", E_ZERO);
  endtask

  initial begin
    reset_n   = 1'b0;
    mem_ack   = 1'b0;
    zero      = 1'b0;
    inst31_21 = '0;

    // Reset state
    #3;
    checkOutput("reset_init", E_ZERO);
    checkCount("reset_init_cnt", 4'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("idle", E_ZERO);
    applyStimulus(1'b0, 1'b0, OP_ADD);
    checkOutput("fetch_wait", E_FETCH_W);

    // Reset in the middle of a pending fetch
    pulseReset();
    applyStimulus(1'b0, 1'b0, OP_ADD);
    checkOutput("fetch_after_reset", E_FETCH_W);
    checkCount("cnt_after_reset", 4'd0);

    // ADD, zero-wait fetch; ack held high in EX_R must be ignored
    applyStimulus(1'b1, 1'b0, OP_ADD);  checkOutput("add_fetch", E_FETCH_A);
    applyStimulus(1'b0, 1'b0, OP_ADD);  checkOutput("add_decode", E_DECODE);
    applyStimulus(1'b1, 1'b0, OP_ADD);  checkOutput("add_ex_r", E_EX_R);
    applyStimulus(1'b0, 1'b0, OP_ADD);  checkOutput("add_wb_r", E_WB_R);
    checkCount("add_cnt_before", 4'd0);
    applyStimulus(1'b0, 1'b0, OP_ADD);  checkOutput("add_next_fetch", E_FETCH_W);
    checkCount("add_cnt", 4'd1);

    // LDUR with three wait cycles on the data access
    applyStimulus(1'b1, 1'b0, OP_LDUR); checkOutput("ld_fetch", E_FETCH_A);
    applyStimulus(1'b0, 1'b0, OP_LDUR); checkOutput("ld_decode", E_DECODE);
    applyStimulus(1'b0, 1'b0, OP_LDUR); checkOutput("ld_ex_addr", E_EXA_LD);
    applyStimulus(1'b0, 1'b0, OP_LDUR); checkOutput("ld_mem_w1", E_MEM_RD);
    applyStimulus(1'b0, 1'b0, OP_LDUR); checkOutput("ld_mem_w2", E_MEM_RD);
    applyStimulus(1'b0, 1'b0, OP_LDUR); checkOutput("ld_mem_w3", E_MEM_RD);
    applyStimulus(1'b1, 1'b0, OP_LDUR); checkOutput("ld_mem_ack", E_MEM_RD);
    applyStimulus(1'b0, 1'b0, OP_LDUR); checkOutput("ld_wb", E_WB_LD);
    applyStimulus(1'b0, 1'b0, OP_LDUR); checkOutput("ld_next_fetch", E_FETCH_W);
    checkCount("ld_cnt", 4'd2);

    // CBZ taken
    applyStimulus(1'b1, 1'b1, OP_CBZ);  checkOutput("cbz1_fetch", E_FETCH_A);
    applyStimulus(1'b0, 1'b1, OP_CBZ);  checkOutput("cbz1_decode", E_DECODE);
    applyStimulus(1'b0, 1'b1, OP_CBZ);  checkOutput("cbz1_taken", E_CBZ_T);
    applyStimulus(1'b0, 1'b1, OP_CBZ);  checkOutput("cbz1_next_fetch", E_FETCH_W);
    checkCount("cbz1_cnt", 4'd3);

    // CBZ not taken
    applyStimulus(1'b1, 1'b0, OP_CBZ);  checkOutput("cbz0_fetch", E_FETCH_A);
    applyStimulus(1'b0, 1'b0, OP_CBZ);  checkOutput("cbz0_decode", E_DECODE);
    applyStimulus(1'b0, 1'b0, OP_CBZ);  checkOutput("cbz0_not_taken", E_CBZ_N);
    applyStimulus(1'b0, 1'b0, OP_CBZ);  checkOutput("cbz0_next_fetch", E_FETCH_W);
    checkCount("cbz0_cnt", 4'd4);

    // ADDI
    applyStimulus(1'b1, 1'b0, OP_ADDI); checkOutput("addi_fetch", E_FETCH_A);
    applyStimulus(1'b0, 1'b0, OP_ADDI); checkOutput("addi_decode", E_DECODE);
    applyStimulus(1'b0, 1'b0, OP_ADDI); checkOutput("addi_ex_i", E_EX_I);
    applyStimulus(1'b0, 1'b0, OP_ADDI); checkOutput("addi_wb_r", E_WB_R);
    applyStimulus(1'b0, 1'b0, OP_ADDI); checkOutput("addi_next_fetch", E_FETCH_W);
    checkCount("addi_cnt", 4'd5);

    // STUR with one wait cycle on the data access
    applyStimulus(1'b1, 1'b0, OP_STUR); checkOutput("st_fetch", E_FETCH_A);
    applyStimulus(1'b0, 1'b0, OP_STUR); checkOutput("st_decode", E_DECODE);
    applyStimulus(1'b0, 1'b0, OP_STUR); checkOutput("st_ex_addr", E_EXA_ST);
    applyStimulus(1'b0, 1'b0, OP_STUR); checkOutput("st_mem_wait", E_MEM_WR_W);
    applyStimulus(1'b1, 1'b0, OP_STUR); checkOutput("st_mem_ack", E_MEM_WR_A);
    applyStimulus(1'b0, 1'b0, OP_STUR); checkOutput("st_next_fetch", E_FETCH_W);
    checkCount("st_cnt", 4'd6);

    // 16 back-to-back B instructions from a cleared counter: wraps 15 -> 0
    pulseReset();
    applyStimulus(1'b0, 1'b0, OP_B);    checkOutput("b_first_fetch", E_FETCH_W);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, OP_B);  checkOutput("b_fetch", E_FETCH_A);
      applyStimulus(1'b0, 1'b0, OP_B);  checkOutput("b_decode", E_DECODE);
      applyStimulus(1'b0, 1'b0, OP_B);  checkOutput("b_branch", E_BR_B);
      applyStimulus(1'b0, 1'b0, OP_B);  checkOutput("b_next_fetch", E_FETCH_W);
      checkCount("b_cnt", CNT_W'(i + 1));
    end
    checkCount("b_wrapped", 4'd0);

    // Illegal opcode: sticky trap, acks ignored, no requests, count holds
    applyStimulus(1'b1, 1'b0, OP_BAD);  checkOutput("bad_fetch", E_FETCH_A);
    applyStimulus(1'b0, 1'b0, OP_BAD);  checkOutput("bad_decode", E_DECODE);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(i[0], 1'b1, OP_BAD);
      checkOutput("trap_hold", E_TRAP);
    end
    checkCount("trap_cnt", 4'd0);
    pulseReset();
    applyStimulus(1'b0, 1'b0, OP_ADD);  checkOutput("trap_cleared_fetch", E_FETCH_W);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
